lsu_dmem_master: RTL and testbench

- Load/store unit that initiates all accesses to the 16-bit word-addressed data memory on behalf of the pipeline MEM stage.
- Accepts byte-addressed LB/LBU/LH/SB/SH requests over a valid/ready handshake and drives the memory's address, write data, write strobe and read strobe.
- Implements byte stores as a read-modify-write sequence, and sign- or zero-extends byte loads.
- Returns one response per request: read data, or an error for a misaligned halfword.

---
 rtl/lsu_dmem_master_if.sv | 33 +++
 rtl/lsu_dmem_master.sv | 154 +++++++++++++++
 tb/tb_lsu_dmem_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_master_if.sv
// Request/response and data-memory bus of the load/store unit.
// master = LSU side, slave = pipeline/memory side.
interface lsu_dmem_master_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [15:0]           req_wdata;
    logic                  resp_valid;
    logic [15:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [15:0]           dmem_wdata;
    logic                  dmem_we;
    logic                  dmem_re;
    logic [15:0]           dmem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               dmem_addr, dmem_wdata, dmem_we, dmem_re
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               dmem_addr, dmem_wdata, dmem_we, dmem_re
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a 16-bit word-addressed data memory; byte stores use read-modify-write.
// Optional LSU_STATS_EN adds saturating load/store/error completion counters.
module lsu_dmem_master #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    lsu_dmem_master_if.master bus
`ifdef LSU_STATS_EN
    ,
    output logic [15:0] o_stat_loads,
    output logic [15:0] o_stat_stores,
    output logic [15:0] o_stat_errs
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LDW,
        RMW_RD,
        RMW_MRG,
        WR,
        ERR,
        RESP
    } state_t;

    state_t                r_state;
    logic                  r_size;
    logic                  r_unsigned;
    logic                  r_lane;
    logic [7:0]            r_byte;
    logic [ADDR_WIDTH-1:0] r_dmemAddr;
    logic [15:0]           r_dmemWdata;
    logic                  r_dmemWe;
    logic                  r_dmemRe;
    logic [15:0]           r_respRdata;

    logic                  w_canAccept;
    logic                  w_accept;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_wordAddr;
    logic [7:0]            w_laneByte;
    logic [15:0]           w_loadData;
    logic [15:0]           w_merged;

    // RESP and ERR are the response-pulse cycles; they behave as idle so a new request can be taken back-to-back.
    assign w_canAccept  = (r_state == IDLE) || (r_state == RESP) || (r_state == ERR);
    assign w_accept     = bus.req_valid && w_canAccept;
    assign w_misaligned = bus.req_size && bus.req_addr[0];
    assign w_wordAddr   = {1'b0, bus.req_addr[ADDR_WIDTH-1:1]};

    assign w_laneByte = r_lane ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0];
    assign w_loadData = r_size ? bus.dmem_rdata
                               : {{8{~r_unsigned & w_laneByte[7]}}, w_laneByte};
    assign w_merged   = r_lane ? {r_byte, bus.dmem_rdata[7:0]}
                               : {bus.dmem_rdata[15:8], r_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_size      <= 1'b0;
            r_unsigned  <= 1'b0;
            r_lane      <= 1'b0;
            r_byte      <= 8'h00;
            r_dmemAddr  <= '0;
            r_dmemWdata <= 16'h0000;
            r_dmemWe    <= 1'b0;
            r_dmemRe    <= 1'b0;
            r_respRdata <= 16'h0000;
        end else begin
            r_dmemWe    <= 1'b0;
            r_dmemRe    <= 1'b0;
            r_respRdata <= 16'h0000;
            case (r_state)
                IDLE, RESP, ERR: begin
                    if (w_accept) begin
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_lane     <= bus.req_addr[0];
                        r_byte     <= bus.req_wdata[7:0];
                        if (w_misaligned) begin
                            r_state <= ERR;
                        end else if (bus.req_we && bus.req_size) begin
                            r_dmemAddr  <= w_wordAddr;
                            r_dmemWdata <= bus.req_wdata;
                            r_dmemWe    <= 1'b1;
                            r_state     <= WR;
                        end else if (bus.req_we) begin
                            r_dmemAddr <= w_wordAddr;
                            r_dmemRe   <= 1'b1;
                            r_state    <= RMW_RD;
                        end else begin
                            r_dmemAddr <= w_wordAddr;
                            r_dmemRe   <= 1'b1;
                            r_state    <= RD;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD:      r_state <= LDW;
                LDW: begin
                    r_respRdata <= w_loadData;
                    r_state     <= RESP;
                end
                RMW_RD:  r_state <= RMW_MRG;
                RMW_MRG: begin
                    r_dmemWdata <= w_merged;
                    r_dmemWe    <= 1'b1;
                    r_state     <= WR;
                end
                WR:      r_state <= RESP;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_canAccept;
    assign bus.resp_valid = (r_state == RESP) || (r_state == ERR);
    assign bus.resp_err   = (r_state == ERR);
    assign bus.resp_rdata = r_respRdata;
    assign bus.dmem_addr  = r_dmemAddr;
    assign bus.dmem_wdata = r_dmemWdata;
    assign bus.dmem_we    = r_dmemWe;
    assign bus.dmem_re    = r_dmemRe;

`ifdef LSU_STATS_EN
    logic [15:0] r_statLoads;
    logic [15:0] r_statStores;
    logic [15:0] r_statErrs;

    // Each counter bumps on the edge into its response cycle and sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statLoads  <= 16'h0000;
            r_statStores <= 16'h0000;
            r_statErrs   <= 16'h0000;
        end else begin
            if (r_state == LDW && r_statLoads != 16'hFFFF)
                r_statLoads <= r_statLoads + 16'd1;
            if (r_state == WR && r_statStores != 16'hFFFF)
                r_statStores <= r_statStores + 16'd1;
            if (w_accept && w_misaligned && r_statErrs != 16'hFFFF)
                r_statErrs <= r_statErrs + 16'd1;
        end
    end

    assign o_stat_loads  = r_statLoads;
    assign o_stat_stores = r_statStores;
    assign o_stat_errs   = r_statErrs;
`endif

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: transaction-level reference model with per-cycle compare,
// directed literal scenarios, then randomized traffic.
module tb_lsu_dmem_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checkCount = 0;
    int   passCount = 0;

    lsu_dmem_master_if #(.ADDR_WIDTH(16)) bus();

`ifdef LSU_STATS_EN
    logic [15:0] statLoads;
    logic [15:0] statStores;
    logic [15:0] statErrs;
`endif

    lsu_dmem_master #(.ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef LSU_STATS_EN
        ,
        .o_stat_loads  (statLoads),
        .o_stat_stores (statStores),
        .o_stat_errs   (statErrs)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous data memory: read data is valid only in the cycle after the read strobe.
    logic [15:0] dutMem [0:32767];
    always @(posedge clk) begin
        if (bus.dmem_we) dutMem[bus.dmem_addr[14:0]] <= bus.dmem_wdata;
        if (bus.dmem_re) bus.dmem_rdata <= dutMem[bus.dmem_addr[14:0]];
        else             bus.dmem_rdata <= 16'($urandom);
    end

    // Reference model state: memory image plus the cycles at which each event is due.
    logic [15:0] refMem [0:32767];
    int          busyUntil = 0;
    int          expRespCycle = -1;
    int          expReCycle = -1;
    int          expWeCycle = -1;
    logic [15:0] expRdata = 16'h0;
    logic        expErr = 1'b0;
    logic [15:0] expAddr = 16'h0;
    logic [15:0] expWdata = 16'h0;

    int          lastRespCycle = -1;
    logic [15:0] lastRespRdata = 16'h0;
    logic        lastRespErr = 1'b0;
    int          lastReCycle = -1;
    logic [15:0] lastReAddr = 16'h0;
    int          lastWeCycle = -1;
    logic [15:0] lastWeAddr = 16'h0;
    logic [15:0] lastWeData = 16'h0;
    int          reCount = 0;
    int          weCount = 0;

    logic [15:0] mWord;
    logic [15:0] mOld;
    logic [7:0]  mLane;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    endtask

    task automatic timeoutFail(input string name);
        checkCount++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cycle);
    endtask

    // Compare process: every cycle out of reset the DUT must match the model's schedule.
    always @(negedge clk) begin
        if (rst) begin
            busyUntil    = 0;
            expRespCycle = -1;
            expReCycle   = -1;
            expWeCycle   = -1;
        end else begin
            checkOutput("req_ready", 32'(bus.req_ready), 32'(cycle >= busyUntil));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(cycle == expRespCycle));
            if (cycle == expRespCycle) begin
                checkOutput("resp_rdata", 32'(bus.resp_rdata), 32'(expRdata));
                checkOutput("resp_err", 32'(bus.resp_err), 32'(expErr));
            end
            if (bus.resp_valid) begin
                lastRespCycle = cycle;
                lastRespRdata = bus.resp_rdata;
                lastRespErr   = bus.resp_err;
            end
            checkOutput("dmem_re", 32'(bus.dmem_re), 32'(cycle == expReCycle));
            checkOutput("dmem_we", 32'(bus.dmem_we), 32'(cycle == expWeCycle));
            if (bus.dmem_re) begin
                reCount++;
                lastReCycle = cycle;
                lastReAddr  = bus.dmem_addr;
            end
            if (bus.dmem_we) begin
                weCount++;
                lastWeCycle = cycle;
                lastWeAddr  = bus.dmem_addr;
                lastWeData  = bus.dmem_wdata;
            end
            if (cycle == expReCycle)
                checkOutput("re_addr", 32'(bus.dmem_addr), 32'(expAddr));
            if (cycle == expWeCycle) begin
                checkOutput("we_addr", 32'(bus.dmem_addr), 32'(expAddr));
                checkOutput("we_data", 32'(bus.dmem_wdata), 32'(expWdata));
                refMem[expAddr[14:0]] = expWdata;
            end
            if (bus.req_valid && bus.req_ready) begin
                mWord    = {1'b0, bus.req_addr[15:1]};
                mOld     = refMem[mWord[14:0]];
                mLane    = bus.req_addr[0] ? mOld[15:8] : mOld[7:0];
                expAddr  = mWord;
                expErr   = 1'b0;
                expRdata = 16'h0;
                if (bus.req_size && bus.req_addr[0]) begin
                    expErr       = 1'b1;
                    expRespCycle = cycle + 1;
                end else if (!bus.req_we) begin
                    expReCycle   = cycle + 1;
                    expRespCycle = cycle + 3;
                    if (bus.req_size)          expRdata = mOld;
                    else if (bus.req_unsigned) expRdata = {8'h00, mLane};
                    else                       expRdata = {{8{mLane[7]}}, mLane};
                end else if (bus.req_size) begin
                    expWeCycle   = cycle + 1;
                    expWdata     = bus.req_wdata;
                    expRespCycle = cycle + 2;
                end else begin
                    expReCycle   = cycle + 1;
                    expWeCycle   = cycle + 3;
                    expWdata     = bus.req_addr[0] ? {bus.req_wdata[7:0], mOld[7:0]}
                                                   : {mOld[15:8], bus.req_wdata[7:0]};
                    expRespCycle = cycle + 4;
                end
                busyUntil = expRespCycle;
            end
        end
    end

    // Present a request just after a rising edge and hold it until accepted.
    task automatic applyStimulus(input logic we, input logic size, input logic uns,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 output int acc);
        int n;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        acc = -1;
        n   = 0;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (bus.req_ready) acc = cycle;
            n++;
        end
        if (acc < 0) timeoutFail("accept");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitResponse(input int after);
        int n;
        bit seen;
        seen = 0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            #1;
            if (lastRespCycle > after) seen = 1;
            n++;
        end
        if (!seen) timeoutFail("response");
    endtask

    task automatic doRequest(input logic we, input logic size, input logic uns,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             output int acc);
        @(posedge clk);
        #1;
        applyStimulus(we, size, uns, addr, wdata, acc);
        waitResponse(acc);
    endtask

    initial begin
        int acc;
        int acc2;
        int reBefore;
        int weBefore;
        logic [15:0] v;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 1'b0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 16'h0;
        bus.req_wdata    = 16'h0;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            dutMem[i] = v;
            refMem[i] = v;
        end
        dutMem[16'h0010] = 16'hA5C3;
        refMem[16'h0010] = 16'hA5C3;

        #12;
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
        checkOutput("rst_re", 32'(bus.dmem_re), 32'd0);
        checkOutput("rst_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_rdata", 32'(bus.resp_rdata), 32'd0);
        checkOutput("rst_addr", 32'(bus.dmem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus.dmem_wdata), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        reBefore = reCount;
        doRequest(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0, acc);
        checkOutput("lb21_rdata", 32'(lastRespRdata), 32'hFFA5);
        checkOutput("lb21_err", 32'(lastRespErr), 32'd0);
        checkOutput("lb21_latency", 32'(lastRespCycle - acc), 32'd3);
        checkOutput("lb21_re_count", 32'(reCount - reBefore), 32'd1);
        checkOutput("lb21_re_cycle", 32'(lastReCycle - acc), 32'd1);
        checkOutput("lb21_re_addr", 32'(lastReAddr), 32'h0010);

        doRequest(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0, acc);
        checkOutput("lbu21_rdata", 32'(lastRespRdata), 32'h00A5);
        doRequest(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, acc);
        checkOutput("lb20_rdata", 32'(lastRespRdata), 32'hFFC3);
        doRequest(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, acc);
        checkOutput("lh20_rdata", 32'(lastRespRdata), 32'hA5C3);

        reBefore = reCount;
        weBefore = weCount;
        doRequest(1'b1, 1'b0, 1'b0, 16'h0021, 16'h1277, acc);
        checkOutput("sb21_re_cycle", 32'(lastReCycle - acc), 32'd1);
        checkOutput("sb21_we_cycle", 32'(lastWeCycle - acc), 32'd3);
        checkOutput("sb21_we_count", 32'(weCount - weBefore), 32'd1);
        checkOutput("sb21_re_count", 32'(reCount - reBefore), 32'd1);
        checkOutput("sb21_we_data", 32'(lastWeData), 32'h77C3);
        checkOutput("sb21_we_addr", 32'(lastWeAddr), 32'h0010);
        checkOutput("sb21_latency", 32'(lastRespCycle - acc), 32'd4);
        doRequest(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, acc);
        checkOutput("lh20_after_sb", 32'(lastRespRdata), 32'h77C3);

        reBefore = reCount;
        weBefore = weCount;
        doRequest(1'b1, 1'b1, 1'b0, 16'h0023, 16'h5555, acc);
        checkOutput("sh23_err", 32'(lastRespErr), 32'd1);
        checkOutput("sh23_rdata", 32'(lastRespRdata), 32'd0);
        checkOutput("sh23_latency", 32'(lastRespCycle - acc), 32'd1);
        checkOutput("sh23_no_re", 32'(reCount - reBefore), 32'd0);
        checkOutput("sh23_no_we", 32'(weCount - weBefore), 32'd0);

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF, acc);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, acc2);
        waitResponse(acc2);
        checkOutput("b2b_we_cycle", 32'(lastWeCycle - acc), 32'd1);
        checkOutput("b2b_accept", 32'(acc2 - acc), 32'd2);
        checkOutput("b2b_latency", 32'(lastRespCycle - acc), 32'd5);
        checkOutput("b2b_rdata", 32'(lastRespRdata), 32'hBEEF);

        // Abandon a byte store while its merge is in progress.
        weBefore = weCount;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0021, 16'h00EE, acc);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("midrst_re", 32'(bus.dmem_re), 32'd0);
        checkOutput("midrst_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_no_we", 32'(weCount - weBefore), 32'd0);
        checkOutput("midrst_word", 32'(dutMem[16'h0010]), 32'h77C3);

        acc = -1;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin
                @(posedge clk);
                #1;
            end
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(16'h0020 + $urandom_range(0, 63));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), a, 16'($urandom), acc);
        end
        waitResponse(acc);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 16'h0010; w < 16'h0030; w++)
            checkOutput("final_mem", 32'(dutMem[w]), 32'(refMem[w]));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
